// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
package mem_arb_pkg;

  localparam int REQ_N = 2;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Load/decrement down-counter timing the memory access; o_last flags the final wait cycle.
module mem_lat_counter #(
  parameter int MAX_VAL = 4,
  parameter int CTR_W   = $clog2(MAX_VAL + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  logic [CTR_W-1:0] r_count;

  // Decrement is gated at zero so a stray i_dec can never wrap the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CTR_W'(MAX_VAL);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CTR_W'(1);
    end
  end

  assign o_last = (r_count == CTR_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between D-cache (req 0) and I-cache/refill (req 1) with internal latency timing.
// Define MEM_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_N-1:0]  req_strobe,
  input  logic [REQ_N-1:0]  req_rw,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [REQ_N-1:0]  req_rdy,
  output logic [DATA_W-1:0] req_rdata,
  output logic              mem_strobe,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  req_id_t           r_grantId;
  req_id_t           w_winner;
  logic              r_memRw;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_reqRdata;
  logic              w_anyReq;
  logic              w_ctrLoad;
  logic              w_ctrDec;
  logic              w_ctrLast;
`ifndef MEM_ARB_FIXED_PRIO_EN
  req_id_t           r_rrLast;
`endif

  assign w_anyReq  = |req_strobe;
  assign w_ctrLoad = (r_state == ISSUE);
  assign w_ctrDec  = (r_state == WAIT);

  mem_lat_counter #(
    .MAX_VAL (MEM_LAT)
  ) u_latCtr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ctrLoad),
    .i_dec  (w_ctrDec),
    .o_last (w_ctrLast)
  );

  // A lone requester always wins; ties go to whoever did not win last time.
  always_comb begin
    w_winner = req_strobe[0] ? 1'b0 : 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
    if (&req_strobe) begin
      w_winner = ~r_rrLast;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (w_ctrLast) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != IDLE);
    mem_strobe = (r_state == ISSUE);
    req_rdy    = '0;
    if (r_state == DONE) begin
      req_rdy[r_grantId] = 1'b1;
    end
  end

  // Request fields are latched once at grant and held for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grantId  <= 1'b0;
      r_memRw    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_reqRdata <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rrLast   <= 1'b1;
`endif
    end else begin
      if ((r_state == IDLE) && w_anyReq) begin
        r_grantId  <= w_winner;
        r_memRw    <= req_rw[w_winner];
        r_memAddr  <= w_winner ? req_addr1 : req_addr0;
        r_memWdata <= w_winner ? req_wdata1 : req_wdata0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        r_rrLast   <= w_winner;
`endif
      end
      if ((r_state == WAIT) && w_ctrLast && !r_memRw) begin
        r_reqRdata <= mem_rdata;
      end
    end
  end

  assign grant_id  = r_grantId;
  assign mem_rw    = r_memRw;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign req_rdata = r_reqRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences and a randomized run
// against a transaction-level reference model. Honours MEM_ARB_FIXED_PRIO_EN when defined.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req_strobe = '0;
  logic [1:0]        req_rw = '0;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [ADDR_W-1:0] req_addr1 = '0;
  logic [DATA_W-1:0] req_wdata0 = '0;
  logic [DATA_W-1:0] req_wdata1 = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        req_rdy;
  logic [DATA_W-1:0] req_rdata;
  logic              mem_strobe;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              grant_id;

  logic [1:0]        l1Strobe = '0;
  logic [1:0]        l1Rw = '0;
  logic [ADDR_W-1:0] l1Addr0 = '0;
  logic [DATA_W-1:0] l1MemRdata = '0;
  logic [1:0]        l1Rdy;
  logic [DATA_W-1:0] l1Rdata;
  logic              l1MemStrobe;
  logic              l1MemRw;
  logic [ADDR_W-1:0] l1MemAddr;
  logic [DATA_W-1:0] l1MemWdata;
  logic              l1Busy;
  logic              l1GrantId;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_strobe(req_strobe), .req_rw(req_rw),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_rdy(req_rdy), .req_rdata(req_rdata),
    .mem_strobe(mem_strobe), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)
  ) u_dutLat1 (
    .clk(clk), .reset(reset),
    .req_strobe(l1Strobe), .req_rw(l1Rw),
    .req_addr0(l1Addr0), .req_addr1(16'h0000),
    .req_wdata0(32'h0), .req_wdata1(32'h0),
    .req_rdy(l1Rdy), .req_rdata(l1Rdata),
    .mem_strobe(l1MemStrobe), .mem_rw(l1MemRw),
    .mem_addr(l1MemAddr), .mem_wdata(l1MemWdata), .mem_rdata(l1MemRdata),
    .busy(l1Busy), .grant_id(l1GrantId)
  );

  typedef struct {
    logic [1:0]        strobe;
    logic [1:0]        rw;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] memData;
    logic              expGrant;
    logic [DATA_W-1:0] expRdata;
  } vec_t;

  vec_t vecs[6];
  vec_t postReset;

  int checkCount = 0;
  int failCount  = 0;

  int                phase;
  logic              owner;
  logic              rrLast;
  logic              expRw;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expWdata;
  logic [DATA_W-1:0] expRdata;
  logic [1:0]        expRdy;
  logic              win;
  bit                active[2];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one full transaction from an IDLE cycle and leaves the DUT in the following IDLE cycle.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    wAddr = v.expGrant ? v.addr1 : v.addr0;
    wData = v.expGrant ? v.wdata1 : v.wdata0;
    checkOutput({tag, ".idleBusy"}, busy, 1'b0);
    req_strobe = v.strobe;
    req_rw     = v.rw;
    req_addr0  = v.addr0;
    req_addr1  = v.addr1;
    req_wdata0 = v.wdata0;
    req_wdata1 = v.wdata1;
    mem_rdata  = 32'hBAD0_0000;
    stepCycle();
    checkOutput({tag, ".memStrobe"}, mem_strobe, 1'b1);
    checkOutput({tag, ".grantId"}, grant_id, v.expGrant);
    checkOutput({tag, ".memRw"}, mem_rw, v.rw[v.expGrant]);
    checkOutput({tag, ".memAddr"}, mem_addr, wAddr);
    checkOutput({tag, ".memWdata"}, mem_wdata, wData);
    for (int c = 2; c <= MEM_LAT + 1; c++) begin
      stepCycle();
      mem_rdata = (c == MEM_LAT + 1) ? v.memData : 32'hBAD0_0000 + DATA_W'(c);
      checkOutput({tag, ".waitStrobe"}, mem_strobe, 1'b0);
      checkOutput({tag, ".waitRdy"}, req_rdy, 2'b00);
    end
    stepCycle();
    checkOutput({tag, ".rdy"}, req_rdy, v.expGrant ? 2'b10 : 2'b01);
    checkOutput({tag, ".rdata"}, req_rdata, v.expRdata);
    checkOutput({tag, ".doneAddr"}, mem_addr, wAddr);
    checkOutput({tag, ".doneWdata"}, mem_wdata, wData);
    stepCycle();
    checkOutput({tag, ".afterRdy"}, req_rdy, 2'b00);
  endtask

  initial begin
    vecs[0] = '{strobe:2'b01, rw:2'b00, addr0:16'h0040, addr1:16'h0000, wdata0:32'h0, wdata1:32'h0,
                memData:32'hDEADBEEF, expGrant:1'b0, expRdata:32'hDEADBEEF};
    vecs[1] = '{strobe:2'b10, rw:2'b10, addr0:16'h0000, addr1:16'h1234, wdata0:32'h0, wdata1:32'hA5A5A5A5,
                memData:32'h0BADBAD0, expGrant:1'b1, expRdata:32'hDEADBEEF};
    vecs[2] = '{strobe:2'b11, rw:2'b00, addr0:16'h0100, addr1:16'h0200, wdata0:32'h1, wdata1:32'h2,
                memData:32'h11111111, expGrant:1'b0, expRdata:32'h11111111};
    vecs[3] = '{strobe:2'b11, rw:2'b00, addr0:16'h0100, addr1:16'h0200, wdata0:32'h1, wdata1:32'h2,
                memData:32'h22222222, expGrant:!FIXED_PRIO, expRdata:32'h22222222};
    vecs[4] = '{strobe:2'b11, rw:2'b00, addr0:16'h0100, addr1:16'h0200, wdata0:32'h1, wdata1:32'h2,
                memData:32'h33333333, expGrant:1'b0, expRdata:32'h33333333};
    vecs[5] = '{strobe:2'b11, rw:2'b00, addr0:16'h0100, addr1:16'h0200, wdata0:32'h1, wdata1:32'h2,
                memData:32'h44444444, expGrant:!FIXED_PRIO, expRdata:32'h44444444};
    postReset = '{strobe:2'b10, rw:2'b00, addr0:16'h0000, addr1:16'h0777, wdata0:32'h0, wdata1:32'h0,
                  memData:32'hCAFEF00D, expGrant:1'b1, expRdata:32'hCAFEF00D};

    #1 reset = 1'b1;
    #1;
    checkOutput("rst.rdy", req_rdy, 2'b00);
    checkOutput("rst.rdata", req_rdata, 32'h0);
    checkOutput("rst.memStrobe", mem_strobe, 1'b0);
    checkOutput("rst.memRw", mem_rw, 1'b0);
    checkOutput("rst.memAddr", mem_addr, 16'h0);
    checkOutput("rst.memWdata", mem_wdata, 32'h0);
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.grantId", grant_id, 1'b0);
    checkOutput("rst.l1Busy", l1Busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stepCycle();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end
    req_strobe = 2'b00;
    stepCycle();

    // Requester 1 arrives while requester 0 is still waiting on memory.
    req_strobe = 2'b01; req_rw = 2'b00; req_addr0 = 16'h0100; req_addr1 = 16'h0200;
    stepCycle();
    checkOutput("late.firstGrant", grant_id, 1'b0);
    stepCycle();
    stepCycle();
    req_strobe[1] = 1'b1;
    repeat (3) stepCycle();
    checkOutput("late.rdy0", req_rdy, 2'b01);
    req_strobe[0] = 1'b0;
    stepCycle();
    checkOutput("late.gapBusy", busy, 1'b0);
    checkOutput("late.gapStrobe", mem_strobe, 1'b0);
    stepCycle();
    checkOutput("late.strobe1", mem_strobe, 1'b1);
    checkOutput("late.grant1", grant_id, 1'b1);
    checkOutput("late.addr1", mem_addr, 16'h0200);
    repeat (MEM_LAT + 1) stepCycle();
    checkOutput("late.rdy1", req_rdy, 2'b10);
    req_strobe = 2'b00;
    stepCycle();

    // Reset in the middle of WAIT drops the transaction.
    req_strobe = 2'b01; req_rw = 2'b00; req_addr0 = 16'h0ABC;
    repeat (3) stepCycle();
    checkOutput("rstw.busyBefore", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstw.rdy", req_rdy, 2'b00);
    checkOutput("rstw.rdata", req_rdata, 32'h0);
    checkOutput("rstw.memStrobe", mem_strobe, 1'b0);
    checkOutput("rstw.memAddr", mem_addr, 16'h0);
    checkOutput("rstw.busy", busy, 1'b0);
    checkOutput("rstw.grantId", grant_id, 1'b0);
    req_strobe = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("rstw.noRdy", req_rdy, 2'b00);
    end
    applyStimulus(postReset, "rstw.next");

    // MEM_LAT=1 instance, strobe dropped during WAIT.
    l1Strobe = 2'b01; l1Rw = 2'b00; l1Addr0 = 16'h0055; l1MemRdata = 32'h0;
    stepCycle();
    checkOutput("lat1.strobe", l1MemStrobe, 1'b1);
    checkOutput("lat1.addr", l1MemAddr, 16'h0055);
    stepCycle();
    l1Strobe = 2'b00;
    l1MemRdata = 32'h600DF00D;
    checkOutput("lat1.waitRdy", l1Rdy, 2'b00);
    stepCycle();
    checkOutput("lat1.rdy", l1Rdy, 2'b01);
    checkOutput("lat1.rdata", l1Rdata, 32'h600DF00D);
    stepCycle();
    checkOutput("lat1.idle", l1Busy, 1'b0);

    // Randomized run against the transaction-level model.
    @(negedge clk);
    reset = 1'b1;
    req_strobe = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
    phase = 0; owner = 1'b0; rrLast = 1'b1; expRdata = '0;
    expRw = 1'b0; expAddr = '0; expWdata = '0;
    active[0] = 1'b0; active[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      expRdy = (phase == MEM_LAT + 2) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      checkOutput("rnd.busy", busy, phase != 0);
      checkOutput("rnd.memStrobe", mem_strobe, phase == 1);
      checkOutput("rnd.rdy", req_rdy, expRdy);
      checkOutput("rnd.rdata", req_rdata, expRdata);
      if (phase != 0) begin
        checkOutput("rnd.grantId", grant_id, owner);
        checkOutput("rnd.memRw", mem_rw, expRw);
        checkOutput("rnd.memAddr", mem_addr, expAddr);
        checkOutput("rnd.memWdata", mem_wdata, expWdata);
      end
      for (int r = 0; r < 2; r++) begin
        if (active[r]) begin
          if ((phase == MEM_LAT + 2) && (owner == r[0])) begin
            active[r] = 1'b0;
            req_strobe[r] = 1'b0;
          end else if ((phase >= 1) && (owner == r[0]) && ($urandom_range(0, 9) == 0)) begin
            req_strobe[r] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          active[r] = 1'b1;
          req_strobe[r] = 1'b1;
          req_rw[r] = 1'($urandom_range(0, 1));
          if (r == 0) begin
            req_addr0 = 16'($urandom); req_wdata0 = $urandom;
          end else begin
            req_addr1 = 16'($urandom); req_wdata1 = $urandom;
          end
        end
      end
      mem_rdata = $urandom;
      if (phase == 0) begin
        if (req_strobe != 2'b00) begin
          if (req_strobe == 2'b11) win = FIXED_PRIO ? 1'b0 : ~rrLast;
          else win = req_strobe[0] ? 1'b0 : 1'b1;
          owner = win;
          rrLast = win;
          expRw = req_rw[win];
          expAddr = win ? req_addr1 : req_addr0;
          expWdata = win ? req_wdata1 : req_wdata0;
          phase = 1;
        end
      end else if (phase == MEM_LAT + 1) begin
        if (!expRw) expRdata = mem_rdata;
        phase++;
      end else if (phase == MEM_LAT + 2) begin
        phase = 0;
      end else begin
        phase++;
      end
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
